// File: rtl/mlp_pkg.sv
// ============================================================================
//  mlp_pkg
//  Shared widths, latency, FSM encoding and saturation helper for the MLP sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mlp_pkg;

   localparam int DW_IN      = 10;
   localparam int DW_OUT     = 11;
   localparam int NEURON_LAT = 2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_CAPTURE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   // Clamp an unsigned neuron result to the neuron input width.
   function automatic logic [DW_IN-1:0] sat(input logic [DW_OUT-1:0] v);
      return v[DW_OUT-1] ? {DW_IN{1'b1}} : v[DW_IN-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/mlp_sequencer.sv
// ============================================================================
//  mlp_sequencer
//  Time-multiplexes one shared 3-input ReLU neuron over the hidden and output layers.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mlp_sequencer #(
   parameter int N_IN       = 2,
   parameter int N_HIDDEN   = 2,
   parameter int NEURON_LAT = mlp_pkg::NEURON_LAT,
   parameter int DW_IN      = mlp_pkg::DW_IN,
   parameter int DW_OUT     = mlp_pkg::DW_OUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DW_IN-1:0]  x0,
   input  logic [DW_IN-1:0]  x1,
   input  logic [DW_IN-1:0]  x2,
   output logic              busy,
   output logic              done,
   output logic [DW_OUT-1:0] y,
   output logic [DW_IN-1:0]  nrn_in1,
   output logic [DW_IN-1:0]  nrn_in2,
   output logic [DW_IN-1:0]  nrn_in3,
   output logic [1:0]        wsel,
   input  logic [DW_OUT-1:0] nrn_out
);
   import mlp_pkg::*;

   localparam int              c_CW        = (NEURON_LAT > 2) ? $clog2(NEURON_LAT) : 1;
   localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'((NEURON_LAT > 1) ? NEURON_LAT - 2 : 0);
   localparam logic [1:0]      c_K_OUT     = 2'(N_HIDDEN);

   state_t            r_state;
   logic [1:0]        r_k;
   logic [c_CW-1:0]   r_wait;
   logic              r_busy;
   logic              r_done;
   logic [DW_OUT-1:0] r_y;
   logic [1:0]        r_wsel;
   logic [DW_IN-1:0]  r_x  [3];
   logic [DW_IN-1:0]  r_h  [3];
   logic [DW_IN-1:0]  r_op [3];

   logic [DW_IN-1:0]  w_h_next   [3];
   logic [DW_IN-1:0]  w_hid_op   [3];
   logic [DW_IN-1:0]  w_out_op   [3];
   logic [1:0]        w_k_inc;

   assign w_k_inc = r_k + 2'd1;

   // The output-neuron operands must see the hidden result captured in the same edge.
   always_comb begin
      w_h_next = r_h;
      if (r_state == S_CAPTURE && r_k < c_K_OUT)
         w_h_next[r_k] = sat(nrn_out);
   end

   for (genvar i = 0; i < 3; i++) begin : g_op
      assign w_hid_op[i] = (i < N_IN)     ? r_x[i]      : '0;
      assign w_out_op[i] = (i < N_HIDDEN) ? w_h_next[i] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_wait  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_y     <= '0;
         r_wsel  <= '0;
         r_x     <= '{default: '0};
         r_h     <= '{default: '0};
         r_op    <= '{default: '0};
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x[0]  <= x0;
                  r_x[1]  <= x1;
                  r_x[2]  <= x2;
                  r_k     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_op    <= w_hid_op;
               r_wsel  <= 2'd0;
               r_state <= S_ISSUE;
            end
            S_ISSUE: begin
               r_wait <= '0;
               if (NEURON_LAT == 1)
                  r_state <= S_CAPTURE;
               else
                  r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wait == c_WAIT_LAST)
                  r_state <= S_CAPTURE;
               else
                  r_wait <= r_wait + 1'b1;
            end
            S_CAPTURE: begin
               if (r_k == c_K_OUT) begin
                  r_y     <= nrn_out;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_h     <= w_h_next;
                  r_k     <= w_k_inc;
                  r_wsel  <= w_k_inc;
                  if (w_k_inc == c_K_OUT)
                     r_op <= w_out_op;
                  else
                     r_op <= w_hid_op;
                  r_state <= S_ISSUE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_op    <= '{default: '0};
               r_wsel  <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign y       = r_y;
   assign wsel    = r_wsel;
   assign nrn_in1 = r_op[0];
   assign nrn_in2 = r_op[1];
   assign nrn_in3 = r_op[2];

endmodule

`default_nettype wire

// File: tb/tb_mlp_sequencer.sv
// ============================================================================
//  tb_mlp_sequencer
//  Self-checking bench: default instance plus a LAT=1 / one-hidden / three-input instance.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mlp_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        start6 = 1'b0;
   logic [9:0]  x0 = '0, x1 = '0, x2 = '0;

   logic        busy, done, busy6, done6;
   logic [10:0] y, y6, nrn_out, nrn_out6;
   logic [9:0]  nrn_in1, nrn_in2, nrn_in3, n6_in1, n6_in2, n6_in3;
   logic [1:0]  wsel, wsel6;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;

   int w [0:2][0:2];
   int bias [0:2];
   bit force_sat = 1'b0;

   always #5 clk = ~clk;

   mlp_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .x0(x0), .x1(x1), .x2(x2),
      .busy(busy), .done(done), .y(y),
      .nrn_in1(nrn_in1), .nrn_in2(nrn_in2), .nrn_in3(nrn_in3),
      .wsel(wsel), .nrn_out(nrn_out)
   );

   mlp_sequencer #(.N_IN(3), .N_HIDDEN(1), .NEURON_LAT(1)) dut6 (
      .clk(clk), .rst_n(rst_n), .start(start6), .x0(x0), .x1(x1), .x2(x2),
      .busy(busy6), .done(done6), .y(y6),
      .nrn_in1(n6_in1), .nrn_in2(n6_in2), .nrn_in3(n6_in3),
      .wsel(wsel6), .nrn_out(nrn_out6)
   );

   // Neuron: weighted sum + bias, ReLU, clamp to 11 bits.
   function automatic logic [10:0] nf(input int bank, input logic [9:0] a, b, c);
      int s;
      if (bank > 2) return 11'd0;
      if (force_sat && bank == 0) return 11'h400;
      s = w[bank][0] * int'(a) + w[bank][1] * int'(b) + w[bank][2] * int'(c) + bias[bank];
      if (s < 0) s = 0;
      if (s > 2047) s = 2047;
      return 11'(s);
   endfunction

   logic [10:0] s1, s2, s1_6;
   always @(posedge clk) begin
      s1   <= nf(int'(wsel), nrn_in1, nrn_in2, nrn_in3);
      s2   <= s1;
      s1_6 <= nf(int'(wsel6), n6_in1, n6_in2, n6_in3);
   end
   assign nrn_out  = s2;
   assign nrn_out6 = s1_6;

   always @(negedge clk) if (done) done_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic ref_model(input int n_in, input int n_h, input logic [9:0] xv [3],
                            output logic [9:0] h [3], output logic [10:0] yv);
      logic [9:0]  op [3];
      logic [10:0] r;
      for (int k = 0; k < 3; k++) h[k] = '0;
      for (int k = 0; k < n_h; k++) begin
         for (int i = 0; i < 3; i++) op[i] = (i < n_in) ? xv[i] : 10'd0;
         r = nf(k, op[0], op[1], op[2]);
         h[k] = (r >= 11'd1024) ? 10'd1023 : 10'(r);
      end
      for (int i = 0; i < 3; i++) op[i] = (i < n_h) ? h[i] : 10'd0;
      yv = nf(n_h, op[0], op[1], op[2]);
   endtask

   task automatic set_xor();
      w = '{'{1, 1, 0}, '{1, 1, 0}, '{1, -2, 0}};
      bias = '{0, -1, 0};
   endtask

   // One inference on the default instance, checked every cycle from LOAD to first IDLE.
   task automatic run_inf(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                          input bit disturb);
      logic [9:0]  xv [3];
      logic [9:0]  h [3];
      logic [9:0]  eop [3];
      logic [10:0] ey;
      int d0, k;
      xv = '{a, b, c};
      ref_model(2, 2, xv, h, ey);
      d0 = done_cnt;
      x0 = a; x1 = b; x2 = c;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         if (disturb) begin
            start = (cyc == 3 || cyc == 11);
            if (cyc == 4) begin
               x0 = 10'($urandom); x1 = 10'($urandom); x2 = 10'($urandom);
            end
         end
         chk("busy", 32'(busy), 32'(cyc <= 11));
         chk("done", 32'(done), 32'(cyc == 11));
         if (cyc >= 2 && cyc <= 10) begin
            k = (cyc - 2) / 3;
            if (k < 2) eop = '{xv[0], xv[1], 10'd0};
            else       eop = '{h[0], h[1], 10'd0};
            chk("wsel", 32'(wsel), 32'(k));
            chk("nrn_in1", 32'(nrn_in1), 32'(eop[0]));
            chk("nrn_in2", 32'(nrn_in2), 32'(eop[1]));
            chk("nrn_in3", 32'(nrn_in3), 32'(eop[2]));
         end else if (cyc != 11) begin
            chk("idle_wsel", 32'(wsel), 32'd0);
            chk("idle_ops", {2'b0, nrn_in1, nrn_in2, nrn_in3}, 32'd0);
         end
         if (cyc >= 11) chk("y", 32'(y), 32'(ey));
         tick();
      end
      start = 1'b0;
      if (disturb) begin
         for (int cyc = 0; cyc < 12; cyc++) begin
            chk("no_restart_busy", 32'(busy), 32'd0);
            tick();
         end
         chk("one_done", 32'(done_cnt - d0), 32'd1);
      end
   endtask

   // One inference on the LAT=1, N_HIDDEN=1, N_IN=3 instance.
   task automatic run6(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
      logic [9:0]  xv [3];
      logic [9:0]  h [3];
      logic [10:0] ey;
      int k;
      xv = '{a, b, c};
      ref_model(3, 1, xv, h, ey);
      x0 = a; x1 = b; x2 = c;
      start6 = 1'b1;
      tick();
      start6 = 1'b0;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         chk("busy6", 32'(busy6), 32'(cyc <= 6));
         chk("done6", 32'(done6), 32'(cyc == 6));
         if (cyc >= 2 && cyc <= 5) begin
            k = (cyc - 2) / 2;
            chk("wsel6", 32'(wsel6), 32'(k));
            chk("n6_in1", 32'(n6_in1), 32'((k == 0) ? xv[0] : h[0]));
            chk("n6_in2", 32'(n6_in2), 32'((k == 0) ? xv[1] : 10'd0));
            chk("n6_in3", 32'(n6_in3), 32'((k == 0) ? xv[2] : 10'd0));
         end
         if (cyc >= 6) chk("y6", 32'(y6), 32'(ey));
         tick();
      end
   endtask

   typedef struct {
      logic [9:0]  a;
      logic [9:0]  b;
      logic [10:0] ey;
   } vec_t;

   vec_t tbl [4];

   initial begin
      int d0;
      tbl[0] = '{10'd0, 10'd0, 11'd0};
      tbl[1] = '{10'd0, 10'd1, 11'd1};
      tbl[2] = '{10'd1, 10'd0, 11'd1};
      tbl[3] = '{10'd1, 10'd1, 11'd0};
      set_xor();

      repeat (2) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_wsel", 32'(wsel), 32'd0);
      chk("rst_ops", {2'b0, nrn_in1, nrn_in2, nrn_in3}, 32'd0);
      chk("rst_busy6", 32'(busy6), 32'd0);
      rst_n = 1'b1;
      tick();

      // Basic run
      run_inf(10'd1, 10'd0, 10'd0, 1'b0);
      chk("basic_y", 32'(y), 32'd1);

      // XOR sweep
      for (int i = 0; i < 4; i++) begin
         run_inf(tbl[i].a, tbl[i].b, 10'($urandom), 1'b0);
         chk("xor_y", 32'(y), 32'(tbl[i].ey));
      end

      // Start ignored while busy and in DONE
      run_inf(10'd1, 10'd0, 10'd0, 1'b1);

      // Saturation of a hidden result
      force_sat = 1'b1;
      w[1] = '{0, 0, 0}; bias[1] = 'h155;
      w[2] = '{1, 1, 0}; bias[2] = 0;
      run_inf(10'd5, 10'd7, 10'd0, 1'b0);
      chk("sat_y", 32'(y), 32'h554);
      force_sat = 1'b0;

      // Asynchronous reset during WAIT of the second hidden neuron
      set_xor();
      d0 = done_cnt;
      x0 = 10'd1; x1 = 10'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk("pre_rst_wsel", 32'(wsel), 32'd1);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_y", 32'(y), 32'd0);
      chk("arst_wsel", 32'(wsel), 32'd0);
      chk("arst_ops", {2'b0, nrn_in1, nrn_in2, nrn_in3}, 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (12) tick();
      chk("arst_no_done", 32'(done_cnt - d0), 32'd0);
      run_inf(10'd0, 10'd1, 10'd0, 1'b0);
      chk("post_rst_y", 32'(y), 32'd1);

      // Randomized weights and inputs against the reference model
      for (int t = 0; t < 16; t++) begin
         for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) w[k][i] = int'($urandom_range(0, 6)) - 3;
            bias[k] = int'($urandom_range(0, 10)) - 5;
         end
         run_inf(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                 10'($urandom), 1'b0);
      end

      // Parameter corner instance
      w = '{'{1, 2, 3}, '{2, 0, 0}, '{0, 0, 0}};
      bias = '{-1, 3, 0};
      run6(10'd1, 10'd2, 10'd3);
      run6(10'd0, 10'd0, 10'd0);
      run6(10'd500, 10'd100, 10'd50);
      for (int t = 0; t < 4; t++)
         run6(10'($urandom_range(0, 300)), 10'($urandom_range(0, 300)), 10'($urandom_range(0, 300)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
